// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Double-buffers the BCD word and commits it only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int PRESCALE         = 100000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LEADING    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    output logic        load_ready,
    output logic [1:0]  digit_sel,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int            PW     = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX   = PW'(PRESCALE - 1);
    localparam logic [3:0]    AN_OFF = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    sel_q, sel_d;
    logic          ftick_q, ftick_d;
    logic [19:0]   shadow_q, shadow_d;
    logic [19:0]   disp_q, disp_d;
    logic          pend_q, pend_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick, commit;
    logic [3:0]    nz, upper_zero, onehot;
    logic [3:0]    cur_nib;
    logic          cur_dp, blank;

    always_comb begin
        tick     = (presc_q == PMAX);
        commit   = tick && (sel_q == 2'd3);
        presc_d  = tick ? '0 : presc_q + PW'(1);
        sel_d    = tick ? sel_q + 2'd1 : sel_q;
        ftick_d  = commit;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        if (load) begin
            shadow_d = {dp_in, bcd_in};
            pend_d   = 1'b1;
        end
        // A load on the commit edge bypasses the shadow and goes straight to display
        if (commit) begin
            if (load) begin
                disp_d = {dp_in, bcd_in};
            end else if (pend_q) begin
                disp_d = shadow_q;
            end
            pend_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nz[i] = |disp_q[4*i +: 4];
        end
        upper_zero[3] = ~nz[3];
        upper_zero[2] = ~nz[3] & ~nz[2];
        upper_zero[1] = ~nz[3] & ~nz[2] & ~nz[1];
        upper_zero[0] = 1'b0;
        cur_nib = disp_q[{sel_q, 2'b00} +: 4];
        cur_dp  = disp_q[16 + {30'd0, sel_q}];
        blank   = BLANK_LEADING && upper_zero[sel_q] && !cur_dp;
        onehot  = 4'b0001 << sel_q;
        an_d    = AN_OFF;
        seg_d   = 7'h7F;
        dp_d    = 1'b1;
        if (!blank) begin
            an_d  = ANODE_ACTIVE_LOW ? ~onehot : onehot;
            seg_d = decode(cur_nib);
            dp_d  = ~cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            sel_q    <= 2'd0;
            ftick_q  <= 1'b0;
            shadow_q <= '0;
            disp_q   <= '0;
            pend_q   <= 1'b0;
            an_q     <= AN_OFF;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            sel_q    <= sel_d;
            ftick_q  <= ftick_d;
            shadow_q <= shadow_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
        end
    end

    assign load_ready = ~pend_q;
    assign digit_sel  = sel_q;
    assign frame_tick = ftick_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: directed frame scenarios plus random loads,
// checked every cycle against a cycle-count based reference model.
module tb_seg7_scan_ctrl;

    localparam int PRESCALE = 4;
    localparam int FRAME    = 4 * PRESCALE;

    logic        clk = 1'b0;
    logic        rst, load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        load_ready, frame_tick, dp;
    logic [1:0]  digit_sel;
    logic [3:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .PRESCALE(PRESCALE),
        .ANODE_ACTIVE_LOW(1'b1),
        .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
        .load_ready(load_ready), .digit_sel(digit_sel), .frame_tick(frame_tick),
        .an(an), .seg(seg), .dp(dp)
    );

    int          ncmp = 0;
    int          nfail = 0;
    int          cnt;
    logic [19:0] m_disp, m_shadow;
    bit          m_pend;
    logic [11:0] m_out;
    bit          m_ft;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // {an, seg, dp} that a digit slot should show for a given display word
    function automatic logic [11:0] exp_disp(input int sel, input logic [19:0] d);
        logic [3:0] nib;
        bit         blank;
        nib   = d[sel*4 +: 4];
        blank = (sel != 0) && ((d[15:0] >> (4*sel)) == 16'h0) && !d[16+sel];
        if (blank) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << sel), glyph(nib), ~d[16+sel]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cnt, obs, exp_v);
        end
    endtask

    task automatic check_all();
        chk("digit_sel",  32'(digit_sel),  32'((cnt / PRESCALE) % 4));
        chk("frame_tick", 32'(frame_tick), 32'(m_ft));
        chk("load_ready", 32'(load_ready), 32'(!m_pend));
        chk("an",         32'(an),         32'(m_out[11:8]));
        chk("seg",        32'(seg),        32'(m_out[7:1]));
        chk("dp",         32'(dp),         32'(m_out[0]));
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        load = 1'b0;
        @(posedge clk); #1;
        cnt = 0; m_disp = '0; m_shadow = '0; m_pend = 0;
        m_out = {4'hF, 7'h7F, 1'b1}; m_ft = 0;
        check_all();
    endtask

    task automatic step(input bit l, input logic [15:0] b, input logic [3:0] d);
        int  sel;
        bit  commit;
        bit  old_pend;
        logic [19:0] old_shadow;
        rst = 1'b0; load = l; bcd_in = b; dp_in = d;
        sel        = (cnt / PRESCALE) % 4;
        commit     = (cnt % FRAME) == FRAME - 1;
        old_pend   = m_pend;
        old_shadow = m_shadow;
        m_out = exp_disp(sel, m_disp);
        m_ft  = commit;
        if (l) begin
            m_shadow = {d, b};
            m_pend   = 1;
        end
        if (commit) begin
            if (l) m_disp = {d, b};
            else if (old_pend) m_disp = old_shadow;
            m_pend = 0;
        end
        cnt++;
        @(posedge clk); #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic advance_to(input int ph);
        for (int i = 0; i < FRAME && (cnt % FRAME) != ph; i++) step(1'b0, 16'h0, 4'h0);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        int r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 15);
            if (r < 5)       v[4*k +: 4] = 4'd0;
            else if (r < 14) v[4*k +: 4] = 4'($urandom_range(0, 9));
            else             v[4*k +: 4] = 4'($urandom_range(10, 15));
        end
        return v;
    endfunction

    initial begin
        rst = 1'b1; load = 1'b0; bcd_in = '0; dp_in = '0; cnt = 0;
        m_disp = '0; m_shadow = '0; m_pend = 0; m_out = '0; m_ft = 0;

        do_reset();
        do_reset();
        idle(40);

        advance_to(6);
        step(1'b1, 16'h1234, 4'h0);
        idle(40);

        step(1'b1, 16'h0007, 4'h0);
        idle(40);

        step(1'b1, 16'h00A0, 4'h0);
        idle(40);
        step(1'b1, 16'h0000, 4'b0100);
        idle(40);

        advance_to(FRAME - 1);
        step(1'b1, 16'h5555, 4'h0);
        idle(40);
        advance_to(3);
        step(1'b1, 16'h1111, 4'h0);
        idle(2);
        step(1'b1, 16'h2222, 4'h0);
        idle(40);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 9) == 0)
                step(1'b1, rand_bcd(), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            else
                step(1'b0, 16'h0, 4'h0);
        end

        idle(20);
        advance_to(5);
        step(1'b1, 16'h9876, 4'h3);
        idle(2);
        do_reset();
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
